serial_addsub_n: RTL

Parametrised bit-serial adder/subtractor. Operands arrive one bit per clock, LSB first. A start/ready/valid handshake frames each operation, and the block reports the full WIDTH-bit result together with carry/borrow and signed overflow. It replaces the fixed 4-bit free-running serial adder in datapaths that need arbitrary operand width, subtraction and explicit operation framing.

---
 rtl/serial_addsub_n_if.sv | 28 ++
 rtl/serial_addsub_n.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_addsub_n_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// master drives the serial operands and start; slave (the datapath) returns status and result.
interface serial_addsub_n_if #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic             sub;
    logic             carryin;
    logic             a;
    logic             b;
    logic             ready;
    logic [WIDTH-1:0] y;
    logic             carryout;
    logic             overflow;
    logic             isValid;
    logic [CW-1:0]    bitcount;

    modport master (
        output start, sub, carryin, a, b,
        input  ready, y, carryout, overflow, isValid, bitcount
    );

    modport slave (
        input  start, sub, carryin, a, b,
        output ready, y, carryout, overflow, isValid, bitcount
    );
endinterface

// File: rtl/serial_addsub_n.sv
// LSB-first bit-serial add/sub of two WIDTH-bit operands; result, carry and overflow valid WIDTH cycles after start.
// No stall path: once started a bit is consumed every cycle; ready is low from RUN through the DONE cycle.
module serial_addsub_n #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    serial_addsub_n_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             c_q, c_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             cin_bit;
    logic             beff;
    logic             sum_bit;
    logic             cnext;
    logic [WIDTH-1:0] y_sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        sub_d   = sub_q;
        y_d     = y_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        // Bit 0 uses the live mode/carry-in; later bits use the captured mode and running carry.
        if (state_q == IDLE) begin
            cin_bit = bus.carryin ^ bus.sub;
            beff    = bus.b ^ bus.sub;
        end else begin
            cin_bit = c_q;
            beff    = bus.b ^ sub_q;
        end
        sum_bit = bus.a ^ beff ^ cin_bit;
        cnext   = (bus.a & beff) | (bus.a & cin_bit) | (beff & cin_bit);

        y_sh            = y_q >> 1;
        y_sh[WIDTH-1]   = sum_bit;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sub_d = bus.sub;
                    c_d   = cnext;
                    y_d   = y_sh;
                    cnt_d = CW'(1);
                    if (WIDTH == 1) begin
                        state_d = DONE;
                        cout_d  = cnext;
                        ovf_d   = cin_bit ^ cnext;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                c_d   = cnext;
                y_d   = y_sh;
                cnt_d = cnt_q + CW'(1);
                // On the MSB, cin_bit is the carry into the sign position.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cout_d  = cnext;
                    ovf_d   = cin_bit ^ cnext;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.isValid  = (state_q == DONE);
    assign bus.y        = y_q;
    assign bus.carryout = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.bitcount = cnt_q;

endmodule
